// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-requester round-robin arbiter and sequencer for a shared single-port memory
module mem_rr_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state, state_nx;
  logic                  ptr, ptr_nx;
  logic                  cmd_port, cmd_port_nx;
  logic                  cmd_we, cmd_we_nx;
  logic                  cmd_ok, cmd_ok_nx;

  logic                  gnt0_nx, gnt1_nx;
  logic                  rvalid0_nx, rvalid1_nx;
  logic                  err0_nx, err1_nx;
  logic [DATA_WIDTH-1:0] rdata0_nx, rdata1_nx;
  logic [ADDR_WIDTH-1:0] mem_addr_nx;
  logic [DATA_WIDTH-1:0] mem_wdata_nx;
  logic                  mem_we_nx;
  logic                  busy_nx;

  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_ok;

  always_comb begin
    sel       = (req0 && req1) ? ptr : req1;
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    sel_ok    = ({1'b0, sel_addr} < DEPTH_W);
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    cmd_port_nx  = cmd_port;
    cmd_we_nx    = cmd_we;
    cmd_ok_nx    = cmd_ok;
    gnt0_nx      = 1'b0;
    gnt1_nx      = 1'b0;
    rvalid0_nx   = 1'b0;
    rvalid1_nx   = 1'b0;
    err0_nx      = 1'b0;
    err1_nx      = 1'b0;
    rdata0_nx    = rdata0;
    rdata1_nx    = rdata1;
    mem_addr_nx  = '0;
    mem_wdata_nx = '0;
    mem_we_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nx    = ACCESS;
          ptr_nx      = ~sel;
          cmd_port_nx = sel;
          cmd_we_nx   = sel_we;
          cmd_ok_nx   = sel_ok;
          gnt0_nx     = ~sel;
          gnt1_nx     = sel;
          // The memory bus is loaded here so it is already valid during ACCESS
          if (sel_ok) begin
            mem_addr_nx  = sel_addr;
            mem_wdata_nx = sel_wdata;
            mem_we_nx    = sel_we;
          end
        end
      end
      ACCESS: begin
        state_nx = RESP;
        if (cmd_ok && !cmd_we) begin
          if (cmd_port) rdata1_nx = mem_rdata;
          else          rdata0_nx = mem_rdata;
        end
        rvalid0_nx = ~cmd_port;
        rvalid1_nx = cmd_port;
        err0_nx    = ~cmd_port & ~cmd_ok;
        err1_nx    = cmd_port & ~cmd_ok;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_ok    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      cmd_port  <= cmd_port_nx;
      cmd_we    <= cmd_we_nx;
      cmd_ok    <= cmd_ok_nx;
      gnt0      <= gnt0_nx;
      gnt1      <= gnt1_nx;
      rvalid0   <= rvalid0_nx;
      rvalid1   <= rvalid1_nx;
      err0      <= err0_nx;
      err1      <= err1_nx;
      rdata0    <= rdata0_nx;
      rdata1    <= rdata1_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      mem_we    <= mem_we_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - scoreboard bench for mem_rr_arbiter with a transaction-level reference model
module tb_mem_rr_arbiter;

  localparam int AW    = 3;
  localparam int DW    = 4;
  localparam int DEPTH = 6;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          port;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem     [8] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
  logic [DW-1:0] ref_mem [8] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

  mem_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t cmdq0[$], cmdq1[$];
  exp_t expq[$];
  logic gnt_log[$];
  int   gnt_cyc[$];

  logic          edge_rst = 1'b0;
  logic          gnt_seen0 = 1'b0, gnt_seen1 = 1'b0;
  logic [DW-1:0] obs_rdata [2] = '{4'h0, 4'h0};
  logic          obs_err   [2] = '{1'b0, 1'b0};
  int            rv_cnt    [2] = '{0, 0};
  int            cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) edge_rst <= rst;

  // Requester drivers: present the head of each command queue, retire it after its grant
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (req0 && gnt_seen0) cmdq0.delete(0);
      if (req1 && gnt_seen1) cmdq1.delete(0);
      if (cmdq0.size() > 0) begin
        req0 = 1'b1; we0 = cmdq0[0].we; addr0 = cmdq0[0].addr; wdata0 = cmdq0[0].wdata;
      end else req0 = 1'b0;
      if (cmdq1.size() > 0) begin
        req1 = 1'b1; we1 = cmdq1[0].we; addr1 = cmdq1[0].addr; wdata1 = cmdq1[0].wdata;
      end else req1 = 1'b0;
    end
  end

  // Reference model and monitor: one transaction = grant cycle, response cycle, idle cycle
  initial begin
    logic          m_access, m_resp, pref, p_req0, p_req1, acc, rsp, w, ok;
    logic [DW-1:0] last_rd [2];
    cmd_t          c;
    exp_t          e;
    m_access = 1'b0; m_resp = 1'b0; pref = 1'b0; p_req0 = 1'b0; p_req1 = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
      chk("rvalid_exclusive", {31'd0, rvalid0 & rvalid1}, 0);
      if (edge_rst) begin
        expq.delete();
        m_access = 1'b0; m_resp = 1'b0; pref = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        chk("reset_quiet", {gnt0, gnt1, rvalid0, rvalid1, busy, mem_we}, 0);
      end else begin
        acc = !m_access && !m_resp && (p_req0 || p_req1);
        rsp = m_access;
        if (acc) begin
          w = (p_req0 && p_req1) ? pref : p_req1;
          c = '0;
          if (!w && cmdq0.size() > 0) c = cmdq0[0];
          else if (w && cmdq1.size() > 0) c = cmdq1[0];
          ok = (int'(c.addr) < DEPTH);
          chk("grant_winner", {gnt1, gnt0}, w ? 2'b10 : 2'b01);
          chk("access_mem_we", mem_we, c.we && ok);
          chk("access_mem_addr", mem_addr, ok ? c.addr : '0);
          if (c.we && ok) chk("access_mem_wdata", mem_wdata, c.wdata);
          if (!c.we && ok) last_rd[w] = ref_mem[c.addr];
          if (c.we && ok) ref_mem[c.addr] = c.wdata;
          e.port = w; e.err = !ok; e.rdata = last_rd[w];
          expq.push_back(e);
          pref = !w;
          gnt_log.push_back(w);
          gnt_cyc.push_back(cyc);
        end else begin
          chk("no_grant", {gnt1, gnt0}, 0);
          chk("idle_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        end
        if (rsp) begin
          if (expq.size() == 0) chk("response_expected", 0, 1);
          else begin
            e = expq.pop_front();
            chk("rvalid_port", {rvalid1, rvalid0}, e.port ? 2'b10 : 2'b01);
            chk("resp_err", e.port ? err1 : err0, e.err);
            chk("resp_rdata", e.port ? rdata1 : rdata0, e.rdata);
          end
        end else begin
          chk("no_rvalid", {rvalid1, rvalid0}, 0);
        end
        chk("busy", busy, acc || rsp);
        m_access = acc;
        m_resp   = rsp;
      end
      if (rvalid0) begin obs_rdata[0] = rdata0; obs_err[0] = err0; rv_cnt[0]++; end
      if (rvalid1) begin obs_rdata[1] = rdata1; obs_err[1] = err1; rv_cnt[1]++; end
      gnt_seen0 = gnt0;
      gnt_seen1 = gnt1;
      p_req0 = req0;
      p_req1 = req1;
    end
  end

  function automatic cmd_t mk(input logic we, input int addr, input int wdata);
    cmd_t c;
    c.we = we; c.addr = AW'(addr); c.wdata = DW'(wdata);
    return c;
  endfunction

  task automatic drain();
    int n = 0;
    while ((cmdq0.size() != 0 || cmdq1.size() != 0 || expq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'd0, n < 300}, 1);
    if (n >= 300) begin cmdq0.delete(); cmdq1.delete(); end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_spacing(input string name);
    for (int i = 0; i + 1 < gnt_cyc.size(); i++)
      chk(name, gnt_cyc[i+1] - gnt_cyc[i], 3);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [3:0] pat;
    int         n;
    int         rv_before;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);       chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
    chk("rst_err0", err0, 0);       chk("rst_err1", err1, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);   chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Write then read back on requester 0
    cmdq0.push_back(mk(1, 3, 'hA));
    drain();
    chk("wr_no_err", obs_err[0], 0);
    cmdq0.push_back(mk(0, 3, 0));
    drain();
    chk("rd_back_A", obs_rdata[0], 'hA);

    // rdata holds across a later write response
    cmdq0.push_back(mk(1, 5, 'h3));
    drain();
    chk("rdata_hold", obs_rdata[0], 'hA);

    // Contention straight out of reset
    @(posedge clk); #1 rst = 1'b1;
    cmdq0.push_back(mk(0, 1, 0)); cmdq0.push_back(mk(0, 1, 0));
    cmdq1.push_back(mk(0, 2, 0)); cmdq1.push_back(mk(0, 2, 0));
    repeat (2) @(posedge clk);
    gnt_log.delete(); gnt_cyc.delete();
    #1 rst = 1'b0;
    drain();
    chk("contention_count", gnt_log.size(), 4);
    pat = '0;
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) pat[i] = gnt_log[i];
    chk("contention_order", pat, 4'b1010);
    check_spacing("contention_spacing");
    chk("contention_rdata1", obs_rdata[1], 'h6);

    // Lone requester 1 is never blocked by the pointer
    gnt_log.delete(); gnt_cyc.delete();
    for (int i = 0; i < 3; i++) cmdq1.push_back(mk(0, i, 0));
    drain();
    chk("single_count", gnt_log.size(), 3);
    pat = '0;
    for (int i = 0; i < 3 && i < gnt_log.size(); i++) pat[i] = gnt_log[i];
    chk("single_all_gnt1", pat, 4'b0111);
    check_spacing("single_spacing");

    // Out-of-range write, then every in-range word read back
    cmdq0.push_back(mk(1, 7, 'h5));
    drain();
    chk("oor_err", obs_err[0], 1);
    for (int a = 0; a < DEPTH; a++) cmdq0.push_back(mk(0, a, 0));
    drain();
    chk("oor_last_read_err", obs_err[0], 0);
    chk("oor_last_read_addr5", obs_rdata[0], 'h3);

    // Reset during the ACCESS cycle of a write
    rv_before = rv_cnt[0];
    cmdq0.push_back(mk(1, 4, 'h9));
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt0 && n < 20);
    chk("midop_gnt_seen", gnt0, 1);
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midop_mem_we", mem_we, 0);
    chk("midop_busy", busy, 0);
    chk("midop_gnt", {gnt1, gnt0}, 0);
    chk("midop_rvalid", {rvalid1, rvalid0}, 0);
    repeat (5) @(negedge clk);
    chk("midop_no_resp", rv_cnt[0], rv_before);

    // Random traffic from both requesters
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cmdq0.size() < 2 && $urandom_range(0, 99) < 40)
        cmdq0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15)));
      if (cmdq1.size() < 2 && $urandom_range(0, 99) < 40)
        cmdq1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer in front of a shared single-port register memory (addr / data_in / wr_enable / data_out style).
- Each requester issues read or write commands over a req/gnt handshake. The arbiter serialises the commands onto the memory port and returns read data with a valid pulse.
- Out-of-range addresses are rejected with an error response. The memory is never touched for them.

Parameters:
- ADDR_WIDTH, 3, width of requester and memory address buses.
- DATA_WIDTH, 4, width of write/read data.
- DEPTH, 8, number of valid memory words. Addresses >= DEPTH are out of range. DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0 / req1  input  1  request from requester 0 / 1; held high with command stable until gnt seen.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  ADDR_WIDTH  command address.
- wdata0 / wdata1  input  DATA_WIDTH  write data.
- gnt0 / gnt1  output  1  one-cycle registered pulse: command accepted.
- rvalid0 / rvalid1  output  1  one-cycle pulse: response (read data or write/err completion) for that requester.
- rdata0 / rdata1  output  DATA_WIDTH  read data, valid with rvalid; holds last value otherwise.
- err0 / err1  output  1  qualifies rvalid: 1 = address out of range.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_we  output  1  memory write enable.
- mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_addr.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on rst. On reset, every output register clears to 0, state goes to IDLE, and the priority pointer goes to 0.
- Registered outputs: all outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise select a winner:
    - only one req high: that requester wins.
    - both high: the requester named by the priority pointer wins.
  - On the edge: latch the winner's we/addr/wdata and index, set gnt_winner=1 for exactly one cycle, flip the priority pointer to the loser, go to ACCESS.
- ACCESS (one cycle):
  - gnt high.
  - In-range address: mem_addr = latched addr. mem_we = latched we. mem_wdata = latched wdata.
  - Out-of-range address: mem_we=0, mem_addr=0.
  - On the edge: capture mem_rdata into rdata_winner (reads, in range only), go to RESP.
- RESP (one cycle):
  - rvalid_winner=1.
  - err_winner=1 if out of range, else 0.
  - mem_we=0.
  - Next state is IDLE.
  - rdata for writes and errors is unchanged.
- Timing:
  - Latency from req sampled (cycle T) to gnt is 1 cycle (T+1).
  - rvalid arrives at T+2.
  - Next arbitration happens at T+3.
  - Throughput is one command per 3 cycles.
- Handshake: requester deasserts req (or presents a new command) on the edge after gnt. A req still high in IDLE is treated as a new command.
- Idle memory bus: mem_addr, mem_wdata and mem_we are 0 outside ACCESS.
- Fairness: with both req continuously high, grants alternate 0,1,0,1. No requester waits more than one other transaction.
- Address range check: addr < DEPTH compared at full ADDR_WIDTH, unsigned.
- Simultaneous events: a req arriving while busy is not sampled until IDLE. gnt0 and gnt1 are never high together, nor are rvalid0 and rvalid1.
- Reset mid-operation: the in-flight command is dropped. mem_we is 0 in the cycle after the reset edge. No gnt or rvalid is produced for the dropped command.

Test Plan:
- Write then read (DEPTH=8): req0 write addr=3 wdata=0xA. Expect gnt0 at T+1, mem_we=1 with mem_addr=3 and mem_wdata=0xA at T+1, rvalid0=1 with err0=0 at T+2. Then req0 read addr=3 → rdata0=0xA with rvalid0 pulse.
- Contention: req0 and req1 both high from reset, reads of addr 1 and 2. Expect gnt0 first, then gnt1, then gnt0 (alternating, 3-cycle spacing), and rvalid1 returns mem[2].
- Single requester fairness: only req1 high continuously. Expect gnt1 every 3 cycles. The priority pointer does not block it.
- Out of range (DEPTH=6, ADDR_WIDTH=3): req0 write addr=7 wdata=0x5. Expect mem_we=0 for the whole transaction, rvalid0=1 with err0=1, and a subsequent read of each addr 0..5 unchanged.
- Reset mid-op: assert rst in the ACCESS cycle of a write to addr 4. Expect mem_we=0, busy=0 and all gnt/rvalid=0 in the next cycle, and no rvalid for the dropped command.
- Hold check: rdata0 keeps 0xA after a later write response to requester 0. gnt and rvalid are never high for both requesters in the same cycle across a 200-cycle random req run.
